// File: rtl/stream_comparator_pkg.sv
// Shared types for the stream comparator: three-way compare result and its
// one-hot flag encoding.
package cmp_pkg;

    typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_res_t;

    // Returns {gt, eq, lt}.
    function automatic logic [2:0] cmp_onehot(input cmp_res_t res);
        logic [2:0] flags;
        flags = 3'b000;
        case (res)
            CMP_GT:  flags = 3'b100;
            CMP_EQ:  flags = 3'b010;
            CMP_LT:  flags = 3'b001;
            default: flags = 3'b000;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/stream_comparator_mode_comparator.sv
// Combinational three-way compare of a against b, signed or unsigned.
module mode_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output cmp_res_t         res
);

    always_comb begin
        res = CMP_EQ;
        if (a == b) begin
            res = CMP_EQ;
        end else if (is_signed && (a[WIDTH-1] != b[WIDTH-1])) begin
            // Differing signs decide outright: the negative operand is smaller.
            res = a[WIDTH-1] ? CMP_LT : CMP_GT;
        end else begin
            // Equal sign bits make the signed order match the magnitude order.
            res = (a < b) ? CMP_LT : CMP_GT;
        end
    end

endmodule

// File: rtl/stream_comparator.sv
// Registered, valid/ready comparator with running min/max/count statistics
// of operand a since the last clear.
module stream_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_gt,
    output logic             out_eq,
    output logic             out_lt,
    output logic             stats_valid,
    output logic [WIDTH-1:0] min_a,
    output logic [WIDTH-1:0] max_a,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic     accept;
    logic     stats_signed;
    cmp_res_t res_cmp;
    cmp_res_t min_cmp;
    cmp_res_t max_cmp;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    mode_comparator #(.WIDTH(WIDTH)) u_res_cmp (
        .a(in_a), .b(in_b), .is_signed(is_signed), .res(res_cmp)
    );

    // Min/max tracking always uses the mode latched by the first sample of the set.
    mode_comparator #(.WIDTH(WIDTH)) u_min_cmp (
        .a(in_a), .b(min_a), .is_signed(stats_signed), .res(min_cmp)
    );

    mode_comparator #(.WIDTH(WIDTH)) u_max_cmp (
        .a(in_a), .b(max_a), .is_signed(stats_signed), .res(max_cmp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_gt       <= 1'b0;
            out_eq       <= 1'b0;
            out_lt       <= 1'b0;
            stats_valid  <= 1'b0;
            stats_signed <= 1'b0;
            min_a        <= '0;
            max_a        <= '0;
            count        <= '0;
        end else begin
            if (accept) begin
                out_valid                <= 1'b1;
                {out_gt, out_eq, out_lt} <= cmp_onehot(res_cmp);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                // A clear in the same cycle makes this sample the first of a new set.
                if (clear || !stats_valid) begin
                    stats_valid  <= 1'b1;
                    stats_signed <= is_signed;
                    min_a        <= in_a;
                    max_a        <= in_a;
                    count        <= {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    if (min_cmp == CMP_LT) min_a <= in_a;
                    if (max_cmp == CMP_GT) max_a <= in_a;
                    if (count != CNT_MAX) count <= count + 1'b1;
                end
            end else if (clear) begin
                stats_valid <= 1'b0;
                min_a       <= '0;
                max_a       <= '0;
                count       <= '0;
            end
        end
    end

endmodule
